// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI timing generator with pixel-tick enable, registered
// outputs and a look-ahead (pre_*) position running PREFETCH ticks ahead.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 12,
  parameter int unsigned PREFETCH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos,
  output logic          line_start,
  output logic          frame_start,
  output logic          pre_de,
  output logic [CW-1:0] pre_x,
  output logic [CW-1:0] pre_y
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  // PREFETCH never exceeds the horizontal blanking, so the offset stays on line 0
  localparam logic [CW-1:0] PRE_H0   = CW'(PREFETCH);

  if ((2 ** CW) <= H_TOTAL || (2 ** CW) <= V_TOTAL) begin : g_cw_check
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end
  if (PREFETCH > H_FP + H_SYNC + H_BP) begin : g_prefetch_check
    $error("vga_timing_gen: PREFETCH exceeds horizontal blanking");
  end

  function automatic logic [2*CW-1:0] advance(input logic [CW-1:0] h,
                                              input logic [CW-1:0] v);
    logic [CW-1:0] hn;
    logic [CW-1:0] vn;
    hn = h + 1'b1;
    vn = v;
    if (h == H_LAST) begin
      hn = '0;
      vn = (v == V_LAST) ? '0 : v + 1'b1;
    end
    return {hn, vn};
  endfunction

  logic [CW-1:0] h_q, v_q, h_d, v_d;
  logic [CW-1:0] ph_q, pv_q, ph_d, pv_d;

  logic          h_sync_q, v_sync_q, de_q, line_start_q, frame_start_q, pre_de_q;
  logic [CW-1:0] x_q, y_q, pre_x_q, pre_y_q;
  logic          h_sync_d, v_sync_d, de_d, line_start_d, frame_start_d, pre_de_d;
  logic [CW-1:0] x_d, y_d, pre_x_d, pre_y_d;

  always_comb begin
    {h_d, v_d}   = advance(h_q, v_q);
    {ph_d, pv_d} = advance(ph_q, pv_q);

    de_d          = (h_q < H_ACT) && (v_q < V_ACT);
    x_d           = de_d ? h_q : '0;
    y_d           = de_d ? v_q : '0;
    h_sync_d      = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
    v_sync_d      = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
    line_start_d  = (h_q == '0) && (v_q < V_ACT);
    frame_start_d = (h_q == '0) && (v_q == '0);

    pre_de_d      = (ph_q < H_ACT) && (pv_q < V_ACT);
    pre_x_d       = pre_de_d ? ph_q : '0;
    pre_y_d       = pre_de_d ? pv_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      ph_q          <= PRE_H0;
      pv_q          <= '0;
      h_sync_q      <= ~HS_POL;
      v_sync_q      <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pre_de_q      <= 1'b0;
      pre_x_q       <= '0;
      pre_y_q       <= '0;
    end else if (en) begin
      h_q           <= h_d;
      v_q           <= v_d;
      ph_q          <= ph_d;
      pv_q          <= pv_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pre_de_q      <= pre_de_d;
      pre_x_q       <= pre_x_d;
      pre_y_q       <= pre_y_d;
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign de          = de_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign pre_de      = pre_de_q;
  assign pre_x       = pre_x_q;
  assign pre_y       = pre_y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: small-timing DUTs checked every cycle against a pixel-index
// model; a default-parameter DUT is checked for line period and sync width.
module tb_vga_timing_gen;

  localparam int HT = 14;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b0;

  logic       hs2, vs2, de2, ls2, fs2, pde2;
  logic [4:0] x2, y2, px2, py2;
  logic       hs0, vs0, de0, ls0, fs0, pde0;
  logic [4:0] x0, y0, px0, py0;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(5), .PREFETCH(2)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .h_sync(hs2), .v_sync(vs2), .de(de2), .x_pos(x2), .y_pos(y2),
    .line_start(ls2), .frame_start(fs2),
    .pre_de(pde2), .pre_x(px2), .pre_y(py2)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(5), .PREFETCH(0)
  ) u_p0 (
    .clk(clk), .rst(rst), .en(en),
    .h_sync(hs0), .v_sync(vs0), .de(de0), .x_pos(x0), .y_pos(y0),
    .line_start(ls0), .frame_start(fs0),
    .pre_de(pde0), .pre_x(px0), .pre_y(py0)
  );

  logic        rst_d = 1'b1;
  logic        en_d  = 1'b1;
  logic        hsd, vsd, ded, lsd, fsd, pded;
  logic [11:0] xd, yd, pxd, pyd;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst_d), .en(en_d),
    .h_sync(hsd), .v_sync(vsd), .de(ded), .x_pos(xd), .y_pos(yd),
    .line_start(lsd), .frame_start(fsd),
    .pre_de(pded), .pre_x(pxd), .pre_y(pyd)
  );

  int tests  = 0;
  int errors = 0;

  typedef struct packed {
    logic [25:0] main;
    logic [25:0] p0;
  } exp_t;
  exp_t sb[$];

  // Expected outputs after n en ticks since reset (n=0: reset values).
  function automatic logic [25:0] model(input int n, input bit no_prefetch);
    logic       hs = 1'b1, vs = 1'b1, d = 1'b0, ls = 1'b0, fs = 1'b0, pd = 1'b0;
    logic [4:0] x = '0, y = '0, px = '0, py = '0;
    int p, h, v, q, qh, qv;
    if (n > 0) begin
      p  = (n - 1) % FT;
      h  = p % HT;
      v  = p / HT;
      d  = (h < 8) && (v < 4);
      if (d) begin
        x = 5'(h);
        y = 5'(v);
      end
      hs = !((h >= 10) && (h < 13));
      vs = !((v >= 5) && (v < 7));
      ls = (h == 0) && (v < 4);
      fs = (p == 0);
      q  = no_prefetch ? p : (p + 2) % FT;
      qh = q % HT;
      qv = q / HT;
      pd = (qh < 8) && (qv < 4);
      if (pd) begin
        px = 5'(qh);
        py = 5'(qv);
      end
    end
    return {hs, vs, d, x, y, ls, fs, pd, px, py};
  endfunction

  int n = 0;

  task automatic step(input logic r, input logic e);
    exp_t ex;
    @(negedge clk);
    rst = r;
    en  = e;
    if (r) n = 0;
    else if (e) n++;
    ex.main = model(n, 1'b0);
    ex.p0   = model(n, 1'b1);
    sb.push_back(ex);
  endtask

  // Monitor: every cycle the DUTs present a registered output vector.
  initial begin
    exp_t        ex;
    logic [25:0] a2, a0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        a2 = {hs2, vs2, de2, x2, y2, ls2, fs2, pde2, px2, py2};
        a0 = {hs0, vs0, de0, x0, y0, ls0, fs0, pde0, px0, py0};
        tests++;
        if (a2 !== ex.main) begin
          errors++;
          $display("FAIL main t=%0t: got %h expected %h", $time, a2, ex.main);
        end
        tests++;
        if (a0 !== ex.p0) begin
          errors++;
          $display("FAIL prefetch0 t=%0t: got %h expected %h", $time, a0, ex.p0);
        end
      end
    end
  end

  task automatic small_stimulus();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (3 * FT) step(1'b0, 1'b1);
    repeat (120) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
    // Reset mid-line at (x=5, y=2) while en is low
    step(1'b1, 1'b0);
    for (int i = 0; i < FT && n < 34; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (1500) step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
    step(1'b1, 1'b0);
  endtask

  task automatic default_check();
    int   cyc = 0, fall1 = -1, fall2 = -1, width = -1, de_cnt = 0, vs_low = 0;
    logic prev;
    @(negedge clk);
    @(negedge clk);
    rst_d = 1'b0;
    @(negedge clk);
    tests++;
    if (hsd !== 1'b1 || ded !== 1'b1 || fsd !== 1'b1) begin
      errors++;
      $display("FAIL def_first_tick: got hs=%b de=%b fs=%b expected hs=1 de=1 fs=1",
               hsd, ded, fsd);
    end
    prev = hsd;
    cyc  = 1;
    de_cnt = ded ? 1 : 0;
    while (cyc < 4000 && (fall2 < 0 || width < 0)) begin
      @(negedge clk);
      cyc++;
      if (cyc <= 1344 && ded) de_cnt++;
      if (vsd !== 1'b1) vs_low++;
      if (prev === 1'b1 && hsd === 1'b0) begin
        if (fall1 < 0) fall1 = cyc;
        else if (fall2 < 0) fall2 = cyc;
      end
      if (prev === 1'b0 && hsd === 1'b1 && fall1 >= 0 && width < 0) width = cyc - fall1;
      prev = hsd;
    end
    tests++;
    if (fall1 < 0 || fall2 < 0 || fall2 - fall1 != 1344) begin
      errors++;
      $display("FAIL def_hsync_period: got %0d expected 1344", fall2 - fall1);
    end
    tests++;
    if (width != 136) begin
      errors++;
      $display("FAIL def_hsync_width: got %0d expected 136", width);
    end
    tests++;
    if (fall1 != 1024 + 24 + 1) begin
      errors++;
      $display("FAIL def_hsync_start: got %0d expected %0d", fall1, 1024 + 24 + 1);
    end
    tests++;
    if (de_cnt != 1024) begin
      errors++;
      $display("FAIL def_de_per_line: got %0d expected 1024", de_cnt);
    end
    tests++;
    if (vs_low != 0) begin
      errors++;
      $display("FAIL def_vsync_idle: got %0d low ticks expected 0", vs_low);
    end
  endtask

  initial begin
    fork
      small_stimulus();
      default_check();
    join
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
